// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle CPU control unit: state encoding,
// instruction field constants, ALU operation codes and the control-word type.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTEXEC   = 4'd6,
      S_RTWB     = 4'd7,
      S_BEQ      = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_ctrl;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

   // Every state starts from this word; only ALU defaults to a non-zero op.
   function automatic ctrl_t ctrl_idle();
      ctrl_t c;
      c          = '0;
      c.alu_ctrl = ALU_ADD;
      return c;
   endfunction

   // Fetch-cycle word before memory answers: read requested, nothing written.
   function automatic ctrl_t ctrl_fetch_wait();
      ctrl_t c;
      c           = ctrl_idle();
      c.mem_read  = 1'b1;
      c.alu_src_b = SRCB_FOUR;
      c.pc_src    = PCSRC_ALU;
      return c;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps an R-type funct field to the ALU operation code and flags any
// funct value that has no defined operation.
module alu_decoder
   import mc_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       legal
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      legal    = 1'b1;
      case (funct)
         FN_ADD:  alu_ctrl = ALU_ADD;
         FN_SUB:  alu_ctrl = ALU_SUB;
         FN_AND:  alu_ctrl = ALU_AND;
         FN_OR:   alu_ctrl = ALU_OR;
         FN_SLT:  alu_ctrl = ALU_SLT;
         default: legal    = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for a five-stage multicycle MIPS-style datapath; drives
// every datapath select/enable from the current state and decoded fields.
module multicycle_controller
   import mc_pkg::*;
#(
   parameter int MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_ctrl,
   output logic       instr_done,
   output logic       illegal
);

   state_t     state;
   state_t     state_next;
   ctrl_t      ctrl;
   logic [2:0] rt_alu_ctrl;
   logic       funct_legal;
   logic       ready;

   assign ready = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

   alu_decoder u_alu_decoder (
      .funct    (funct),
      .alu_ctrl (rt_alu_ctrl),
      .legal    (funct_legal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      ctrl       = ctrl_idle();
      state_next = state;
      case (state)
         S_FETCH: begin
            ctrl = ctrl_fetch_wait();
            if (ready) begin
               ctrl.ir_write = 1'b1;
               ctrl.pc_write = 1'b1;
               state_next    = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target is precomputed here so BEQ can use ALUOut.
            ctrl.alu_src_b = SRCB_IMM_SH;
            case (opcode)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE: begin
                  if (funct_legal) begin
                     state_next = S_RTEXEC;
                  end else begin
                     ctrl.illegal = 1'b1;
                     state_next   = S_FETCH;
                  end
               end
               OP_BEQ:  state_next = S_BEQ;
               OP_ADDI: state_next = S_ADDIEXEC;
               OP_J:    state_next = S_JUMP;
               default: begin
                  ctrl.illegal = 1'b1;
                  state_next   = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            state_next     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
            if (ready) begin
               state_next = S_MEMWB;
            end
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
            state_next      = S_FETCH;
         end
         S_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
            if (ready) begin
               ctrl.instr_done = 1'b1;
               state_next      = S_FETCH;
            end
         end
         S_RTEXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_ctrl  = rt_alu_ctrl;
            state_next     = S_RTWB;
         end
         S_RTWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
            state_next      = S_FETCH;
         end
         S_BEQ: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REG;
            ctrl.alu_ctrl      = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_src        = PCSRC_ALUOUT;
            ctrl.instr_done    = 1'b1;
            state_next         = S_FETCH;
         end
         S_ADDIEXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            state_next     = S_ADDIWB;
         end
         S_ADDIWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
            state_next      = S_FETCH;
         end
         S_JUMP: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_src     = PCSRC_JUMP;
            ctrl.instr_done = 1'b1;
            state_next      = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase
      // While reset is held the datapath sees an idle fetch, so no write can leak.
      if (rst) begin
         ctrl       = ctrl_fetch_wait();
         state_next = S_FETCH;
      end
   end

   assign pc_en      = ctrl.pc_write | (ctrl.pc_write_cond & zero);
   assign iord       = ctrl.iord;
   assign mem_read   = ctrl.mem_read;
   assign mem_write  = ctrl.mem_write;
   assign ir_write   = ctrl.ir_write;
   assign reg_write  = ctrl.reg_write;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign pc_src     = ctrl.pc_src;
   assign alu_ctrl   = ctrl.alu_ctrl;
   assign instr_done = ctrl.instr_done;
   assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller; expected control
// words come from an instruction-level step list built in the bench.
module tb_multicycle_controller;

   localparam int K_FETCH = 0, K_DECODE = 1, K_MEMADR = 2, K_MEMRD = 3,
                  K_MEMWB = 4, K_MEMWR = 5, K_RTEXEC = 6, K_RTWB = 7,
                  K_BEQ = 8, K_ADDIEXEC = 9, K_ADDIWB = 10, K_JUMP = 11;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
   logic       reg_dst, mem_to_reg, alu_src_a, instr_done, illegal;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_ctrl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.MEM_WAIT(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_en      (pc_en),
      .iord       (iord),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .pc_src     (pc_src),
      .alu_ctrl   (alu_ctrl),
      .instr_done (instr_done),
      .illegal    (illegal)
   );

   wire [17:0] obs = {pc_en, iord, mem_read, mem_write, ir_write, reg_write,
                      reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
                      alu_ctrl, instr_done, illegal};

   task automatic check(input string tag, input logic [17:0] got, input logic [17:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%b want=%b (pe,io,mr,mw,irw,rw,rd,m2r,sa,sb2,ps2,ac3,dn,il)",
                  tag, got, want);
      end
   endtask

   function automatic bit funct_ok(input logic [5:0] fn);
      return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
             fn == 6'b100101 || fn == 6'b101010;
   endfunction

   function automatic logic [2:0] alu_for(input logic [5:0] fn);
      case (fn)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic bit opcode_known(input logic [5:0] op);
      return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
             op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
   endfunction

   // Expected control word for one cycle of a given instruction step.
   function automatic logic [17:0] expv(input int k, input bit rdy, input bit z,
                                         input bit ill, input logic [5:0] fn);
      logic pe = 0, io = 0, mr = 0, mw = 0, irw = 0, rw = 0, rd = 0, m2r = 0, sa = 0;
      logic [1:0] sb = 2'b00, ps = 2'b00;
      logic [2:0] ac = 3'b010;
      logic dn = 0, il = 0;
      case (k)
         K_FETCH:    begin mr = 1; sb = 2'b01; irw = rdy; pe = rdy; end
         K_DECODE:   begin sb = 2'b11; il = ill; end
         K_MEMADR:   begin sa = 1; sb = 2'b10; end
         K_MEMRD:    begin mr = 1; io = 1; end
         K_MEMWB:    begin rw = 1; m2r = 1; dn = 1; end
         K_MEMWR:    begin mw = 1; io = 1; dn = rdy; end
         K_RTEXEC:   begin sa = 1; ac = alu_for(fn); end
         K_RTWB:     begin rw = 1; rd = 1; dn = 1; end
         K_BEQ:      begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; dn = 1; end
         K_ADDIEXEC: begin sa = 1; sb = 2'b10; end
         K_ADDIWB:   begin rw = 1; dn = 1; end
         K_JUMP:     begin pe = 1; ps = 2'b10; dn = 1; end
         default:    ;
      endcase
      return {pe, io, mr, mw, irw, rw, rd, m2r, sa, sb, ps, ac, dn, il};
   endfunction

   // Called just after a rising edge; checks at the falling edge.
   task automatic step(input int k, input bit rdy, input bit ill, input string tag);
      mem_ready = rdy;
      @(negedge clk);
      check($sformatf("%s k%0d", tag, k), obs, expv(k, rdy, zero, ill, funct));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_step(input int k, input int waits, input string tag);
      repeat (waits) step(k, 1'b0, 1'b0, tag);
      step(k, 1'b1, 1'b0, tag);
   endtask

   task automatic reset_cycles(input int n, input bit rdy);
      rst       = 1'b1;
      mem_ready = rdy;
      repeat (n) begin
         @(negedge clk);
         check("reset", obs, expv(K_FETCH, 1'b0, zero, 1'b0, funct));
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                            input int fw, input int mw, input string tag);
      bit ill;
      opcode = op;
      funct  = fn;
      zero   = z;
      ill    = !opcode_known(op) || (op == 6'b000000 && !funct_ok(fn));
      wait_step(K_FETCH, fw, tag);
      step(K_DECODE, 1'($urandom_range(0, 1)), ill, tag);
      if (ill) return;
      case (op)
         6'b100011: begin
            step(K_MEMADR, 1'($urandom_range(0, 1)), 1'b0, tag);
            wait_step(K_MEMRD, mw, tag);
            step(K_MEMWB, 1'($urandom_range(0, 1)), 1'b0, tag);
         end
         6'b101011: begin
            step(K_MEMADR, 1'($urandom_range(0, 1)), 1'b0, tag);
            wait_step(K_MEMWR, mw, tag);
         end
         6'b000000: begin
            step(K_RTEXEC, 1'($urandom_range(0, 1)), 1'b0, tag);
            step(K_RTWB, 1'($urandom_range(0, 1)), 1'b0, tag);
         end
         6'b000100: step(K_BEQ, 1'($urandom_range(0, 1)), 1'b0, tag);
         6'b001000: begin
            step(K_ADDIEXEC, 1'($urandom_range(0, 1)), 1'b0, tag);
            step(K_ADDIWB, 1'($urandom_range(0, 1)), 1'b0, tag);
         end
         default:   step(K_JUMP, 1'($urandom_range(0, 1)), 1'b0, tag);
      endcase
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0] ops [6];
      logic [5:0] fns [5];
      logic [5:0] op, fn;
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      opcode = 6'b000000;
      funct  = 6'b100000;
      zero   = 1'b0;
      @(posedge clk);
      #1;
      reset_cycles(2, 1'b1);
      step(K_FETCH, 1'b0, 1'b0, "post_reset");
      step(K_FETCH, 1'b0, 1'b0, "post_reset");

      run_instr(6'b100011, 6'b000000, 1'b0, 0, 0, "lw_nowait");
      run_instr(6'b101011, 6'b000000, 1'b0, 0, 3, "sw_wait3");
      run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, "beq_z1");
      run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, "beq_z0");
      run_instr(6'b000000, 6'b101010, 1'b0, 0, 0, "rt_slt");
      run_instr(6'b000000, 6'b000000, 1'b0, 0, 0, "rt_badfn");
      run_instr(6'b001000, 6'b000000, 1'b0, 1, 0, "addi");
      run_instr(6'b000010, 6'b000000, 1'b0, 2, 0, "jump");
      run_instr(6'b111111, 6'b100000, 1'b0, 0, 0, "bad_op");

      // Reset during a load's memory wait must abandon the load.
      opcode = 6'b100011;
      step(K_FETCH, 1'b1, 1'b0, "lw_rst");
      step(K_DECODE, 1'b0, 1'b0, "lw_rst");
      step(K_MEMADR, 1'b0, 1'b0, "lw_rst");
      step(K_MEMRD, 1'b0, 1'b0, "lw_rst");
      step(K_MEMRD, 1'b0, 1'b0, "lw_rst");
      reset_cycles(1, 1'b1);
      step(K_FETCH, 1'b0, 1'b0, "lw_rst_after");
      step(K_FETCH, 1'b0, 1'b0, "lw_rst_after");

      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            do op = 6'($urandom); while (opcode_known(op));
         end else begin
            op = ops[$urandom_range(0, 5)];
         end
         if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
         else fn = fns[$urandom_range(0, 4)];
         run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                   $urandom_range(0, 3), $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
